// File: rtl/axi_rd_mux_nx1.sv
// axi_rd_mux_nx1: N:1 AXI4 read-channel multiplexer.
// The AR channel uses QoS-first, round-robin-second arbitration into a single
// output register slot. The source index is prepended to the ID. Per-source
// outstanding-burst counters gate eligibility. R beats are routed back
// combinationally using the index field of m_axi_rid.
module axi_rd_mux_nx1 #(
  parameter int S_COUNT         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int S_ID_WIDTH      = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int QOS_ENABLE      = 1,
  localparam int SIDX_W         = $clog2(S_COUNT),
  localparam int M_ID_WIDTH     = S_ID_WIDTH + SIDX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [S_COUNT*S_ID_WIDTH-1:0] s_axi_arid,
  input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [S_COUNT*8-1:0]          s_axi_arlen,
  input  logic [S_COUNT*4-1:0]          s_axi_arqos,
  input  logic [S_COUNT-1:0]            s_axi_arvalid,
  output logic [S_COUNT-1:0]            s_axi_arready,
  output logic [S_COUNT*S_ID_WIDTH-1:0] s_axi_rid,
  output logic [S_COUNT*DATA_WIDTH-1:0] s_axi_rdata,
  output logic [S_COUNT*2-1:0]          s_axi_rresp,
  output logic [S_COUNT-1:0]            s_axi_rlast,
  output logic [S_COUNT-1:0]            s_axi_rvalid,
  input  logic [S_COUNT-1:0]            s_axi_rready,
  output logic [M_ID_WIDTH-1:0]         m_axi_arid,
  output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [3:0]                    m_axi_arqos,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [M_ID_WIDTH-1:0]         m_axi_rid,
  input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  output logic                          rid_err
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Unpacked views of the source-side AR buses
  logic [S_ID_WIDTH-1:0] src_id   [S_COUNT];
  logic [ADDR_WIDTH-1:0] src_addr [S_COUNT];
  logic [7:0]            src_len  [S_COUNT];
  logic [3:0]            src_qos  [S_COUNT];

  logic [S_COUNT-1:0]    eligible;
  logic [S_COUNT-1:0]    cand;
  logic [S_COUNT-1:0]    cand_rot;
  logic [S_COUNT-1:0]    r_route;
  logic [3:0]            max_qos;
  logic [SIDX_W-1:0]     ptr_reg;
  logic [SIDX_W-1:0]     off;
  logic [SIDX_W-1:0]     winner;
  logic [SIDX_W:0]       sum;
  logic                  found;
  logic                  slot_free;
  logic                  grant_valid;

  logic                  m_arvalid_reg;
  logic [M_ID_WIDTH-1:0] m_arid_reg;
  logic [ADDR_WIDTH-1:0] m_araddr_reg;
  logic [7:0]            m_arlen_reg;
  logic [3:0]            m_arqos_reg;
  logic                  rid_err_reg;

  logic [SIDX_W-1:0]     r_idx;
  logic                  r_idx_ok;
  logic                  rlast_hs;

  // The output slot can take a new request when it is empty or draining this cycle
  assign slot_free   = !m_arvalid_reg || m_axi_arready;
  assign grant_valid = !rst && slot_free && found;

  // R routing: the index field selects the source; unknown indices are sunk
  assign r_idx    = m_axi_rid[M_ID_WIDTH-1 -: SIDX_W];
  assign r_idx_ok = ({1'b0, r_idx} < (SIDX_W+1)'(S_COUNT));
  assign m_axi_rready = r_idx_ok ? s_axi_rready[r_idx] : 1'b1;
  assign rlast_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  genvar gi;
  generate
    for (gi = 0; gi < S_COUNT; gi++) begin : g_src
      logic [CNT_W-1:0] count_reg;
      logic             inc;
      logic             dec;

      assign src_id[gi]   = s_axi_arid[gi*S_ID_WIDTH +: S_ID_WIDTH];
      assign src_addr[gi] = s_axi_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign src_len[gi]  = s_axi_arlen[gi*8 +: 8];
      assign src_qos[gi]  = s_axi_arqos[gi*4 +: 4];

      // A source competes only while it has outstanding-burst headroom
      assign eligible[gi] = s_axi_arvalid[gi] && (count_reg < CNT_W'(MAX_OUTSTANDING));
      assign cand[gi]     = eligible[gi] && ((QOS_ENABLE == 0) || (src_qos[gi] == max_qos));

      assign s_axi_arready[gi] = grant_valid && (winner == SIDX_W'(gi));
      assign r_route[gi]       = r_idx_ok && (r_idx == SIDX_W'(gi));
      assign s_axi_rvalid[gi]  = m_axi_rvalid && r_route[gi];

      // Return data fields are broadcast; only rvalid is steered
      assign s_axi_rid[gi*S_ID_WIDTH +: S_ID_WIDTH]   = m_axi_rid[S_ID_WIDTH-1:0];
      assign s_axi_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
      assign s_axi_rresp[gi*2 +: 2]                   = m_axi_rresp;
      assign s_axi_rlast[gi]                          = m_axi_rlast;

      assign inc = s_axi_arready[gi];
      assign dec = rlast_hs && r_route[gi];

      // Outstanding-burst counter; simultaneous accept and completion cancel
      always_ff @(posedge clk) begin
        if (rst) begin
          count_reg <= '0;
        end else if (inc && !dec) begin
          count_reg <= count_reg + 1'b1;
        end else if (dec && !inc && (count_reg != '0)) begin
          count_reg <= count_reg - 1'b1;
        end
      end
    end
  endgenerate

  // Highest QoS value among eligible sources
  always_comb begin
    max_qos = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      if (eligible[i] && (src_qos[i] > max_qos)) begin
        max_qos = src_qos[i];
      end
    end
  end

  // Round-robin pick: rotate candidates so the pointer is bit 0, take the lowest set bit
  always_comb begin
    cand_rot = S_COUNT'({cand, cand} >> ptr_reg);
    off      = '0;
    found    = 1'b0;
    for (int k = S_COUNT - 1; k >= 0; k--) begin
      if (cand_rot[k]) begin
        off   = SIDX_W'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr_reg} + {1'b0, off};
    if (sum >= (SIDX_W+1)'(S_COUNT)) begin
      sum = sum - (SIDX_W+1)'(S_COUNT);
    end
    winner = sum[SIDX_W-1:0];
  end

  // AR slot valid flag and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      m_arvalid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else if (grant_valid) begin
      m_arvalid_reg <= 1'b1;
      ptr_reg       <= (winner == SIDX_W'(S_COUNT - 1)) ? '0 : winner + 1'b1;
    end else if (m_axi_arready) begin
      m_arvalid_reg <= 1'b0;
    end
  end

  // AR payload capture; held while the slot waits for m_axi_arready
  always_ff @(posedge clk) begin
    if (grant_valid) begin
      m_arid_reg   <= {winner, src_id[winner]};
      m_araddr_reg <= src_addr[winner];
      m_arlen_reg  <= src_len[winner];
      m_arqos_reg  <= src_qos[winner];
    end
  end

  // One-cycle error pulse for each beat carrying an out-of-range source index
  always_ff @(posedge clk) begin
    if (rst) begin
      rid_err_reg <= 1'b0;
    end else begin
      rid_err_reg <= m_axi_rvalid && !r_idx_ok;
    end
  end

  assign m_axi_arvalid = m_arvalid_reg;
  assign m_axi_arid    = m_arid_reg;
  assign m_axi_araddr  = m_araddr_reg;
  assign m_axi_arlen   = m_arlen_reg;
  assign m_axi_arqos   = m_arqos_reg;
  assign rid_err       = rid_err_reg;

endmodule

// File: doc/axi_rd_mux_nx1.md
Name:
axi_rd_mux_nx1

Overview:
Parametrised N:1 AXI4 read-channel multiplexer, the read-path successor of the fixed 2x1 interconnect wrapper. It replaces hard-wired 2-port concatenation with S_COUNT sources, QoS-aware round-robin AR arbitration, source-index ID extension, per-source outstanding-burst limits and ID-routed R return. It sits between multiple read masters (DMA, cache refill) and one memory-side AXI4 slave.

Parameters:
S_COUNT, 4, number of source ports (>=2)
DATA_WIDTH, 32, R data width
ADDR_WIDTH, 32, address width
S_ID_WIDTH, 4, source-side ID width; M_ID_WIDTH = S_ID_WIDTH + $clog2(S_COUNT) (localparam)
MAX_OUTSTANDING, 8, maximum accepted-but-incomplete bursts per source (>=1)
QOS_ENABLE, 1, 1: arqos priority before round-robin; 0: pure round-robin

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axi_arid  in  S_COUNT*S_ID_WIDTH  source AR IDs, source i at slice i
s_axi_araddr  in  S_COUNT*ADDR_WIDTH  source addresses
s_axi_arlen  in  S_COUNT*8  source burst lengths
s_axi_arqos  in  S_COUNT*4  source QoS
s_axi_arvalid  in  S_COUNT  source AR valid
s_axi_arready  out  S_COUNT  source AR ready
s_axi_rid  out  S_COUNT*S_ID_WIDTH  returned ID (low bits of m_axi_rid, broadcast)
s_axi_rdata  out  S_COUNT*DATA_WIDTH  read data (broadcast)
s_axi_rresp  out  S_COUNT*2  response (broadcast)
s_axi_rlast  out  S_COUNT  last beat (broadcast)
s_axi_rvalid  out  S_COUNT  R valid, only the routed source
s_axi_rready  in  S_COUNT  source R ready
m_axi_arid  out  M_ID_WIDTH  {source index, source ID}
m_axi_araddr  out  ADDR_WIDTH  granted address
m_axi_arlen  out  8  granted length
m_axi_arqos  out  4  granted QoS
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid  in  M_ID_WIDTH  returned ID
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  response
m_axi_rlast  in  1  last beat
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
rid_err  out  1  one-cycle pulse: R beat with source index >= S_COUNT dropped

Behaviour:
- Reset (sync, active-high): m_axi_arvalid=0, s_axi_arready=0, all outstanding counters=0, round-robin pointer=0 (index 0 has highest tie priority), rid_err=0. Bursts in flight at reset are abandoned; counters restart from 0.
- Sources carry INCR bursts at full DATA_WIDTH. arsize/arburst/arprot are not carried; top level drives master-side constants.
- AR stage: one output register slot. Slot is free when m_axi_arvalid=0 or m_axi_arready=1 in the same cycle.
- Eligible source i: s_axi_arvalid[i]=1 and count[i] < MAX_OUTSTANDING.
- Arbitration runs only when the slot is free. QOS_ENABLE=1: highest arqos among eligible sources wins; ties go round-robin starting at pointer. QOS_ENABLE=0: round-robin only.
- Grant: s_axi_arready[winner]=1 combinationally in that cycle, all other arready=0. Payload is registered and m_axi_arvalid=1 the next cycle (AR latency 1). Pointer <= winner+1 mod S_COUNT. Back-to-back grants are possible every cycle while m_axi_arready=1.
- m_axi_arvalid stays asserted with stable payload until m_axi_arready=1.
- count[i]: +1 on s-side AR handshake for i. -1 on R handshake (m_axi_rvalid & m_axi_rready & m_axi_rlast) routed to i. Both in the same cycle: unchanged. Width $clog2(MAX_OUTSTANDING+1).
- R path is combinational, zero latency. idx = m_axi_rid[M_ID_WIDTH-1 -: $clog2(S_COUNT)]. s_axi_rvalid[idx]=m_axi_rvalid, others 0. m_axi_rready=s_axi_rready[idx].
- idx >= S_COUNT (non-power-of-2 S_COUNT): m_axi_rready=1, beat sunk, no s_axi_rvalid. rid_err is registered high for one cycle per dropped beat.

Test Plan:
- Reset, then S_COUNT=4 with all arvalid held and QoS equal -> grants in order 0,1,2,3,0; m_axi_arid top bits 00,01,10,11,00 with one AR per cycle while m_axi_arready=1.
- QOS_ENABLE=1, source 2 arqos=8 and others 0, all valid -> source 2 is granted repeatedly until its count reaches MAX_OUTSTANDING=8, then round-robin resumes among 0,1,3.
- m_axi_arready low 5 cycles after a grant -> m_axi_arvalid and payload stay stable, all s_axi_arready=0, no further grant until release.
- m_axi_rid={2'b01,4'h5}, 4-beat burst, s_axi_rready[1] toggling -> only s_axi_rvalid[1] asserts, s_axi_rid[1]=4'h5, count[1] decrements once on rlast.
- AR accept and rlast for source 0 in the same cycle with count[0]=3 -> count[0] stays 3.
- S_COUNT=3, m_axi_rid index 2'b11 beat -> m_axi_rready=1, no s_axi_rvalid, rid_err pulses one cycle. Reset mid-burst -> all counters 0, m_axi_arvalid=0 next cycle.
